seg_scroll_ctrl: RTL
====================

Name: seg_scroll_ctrl

Overview:
Controller that sequences a 4-digit multiplexed seven-segment display, scrolling a short message of active-low segment codes across the digits. It holds a writable message buffer and divides the system clock into digit-refresh and scroll ticks. It runs a run/hold/idle control FSM and drives the active-low anode and segment lines of the board display. It sits between top-level control (buttons/switch logic) and the display pins.

Parameters:
REFRESH_DIV, 4, clock cycles each digit is lit (≥2)
SCROLL_FRAMES, 2, full 4-digit frames per scroll step (≥1)
MSG_LEN, 5, message length in characters (2..16)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
start  in  1  start/resume request (level sampled each cycle)
stop  in  1  pause/stop request (level sampled each cycle)
wr_en  in  1  message buffer write strobe
wr_addr  in  4  message buffer write index
wr_data  in  8  segment code to write (active-low, bit7 = dp)
an  out  4  digit enables, active-low, an[3] = leftmost
seg  out  8  segment lines, active-low
busy  out  1  high in RUN or HOLD
wrap  out  1  one-cycle pulse when scroll offset wraps to 0

Behaviour:
- Reset (async, active-high): state=IDLE; an=4'hF; seg=8'hFF; busy=0; wrap=0; all counters 0; buffer[0..4]=C7,A3,C7,EF,89; buffer[5..MSG_LEN-1]=FF.
- FSM: IDLE, RUN, HOLD. Transitions are evaluated every cycle:
  - IDLE: start → RUN. Counters and offset clear.
  - RUN: stop → HOLD.
  - HOLD: stop → IDLE. Otherwise start → RUN (resume, counters kept).
  - start and stop together: stop wins.
- Refresh counter rc runs 0..REFRESH_DIV-1 in RUN and HOLD. A tick occurs when rc = REFRESH_DIV-1.
- On each tick, the digit index d advances 0→1→2→3→0. A frame ends on a tick with d=3.
- At frame end, frame counter fc increments mod SCROLL_FRAMES. A scroll step occurs when fc wraps.
- On a scroll step in RUN only, offset advances mod MSG_LEN. In HOLD, offset is frozen; rc, d and fc keep counting.
- wrap=1 for exactly the cycle after offset goes MSG_LEN-1 → 0.
- Digit d displays buffer[(offset+d) mod MSG_LEN] on anode an[3-d], with only that anode low.
- an and seg are registered with 1-cycle latency from the d/offset/state registers.
- IDLE outputs: an=F, seg=FF, registered. The display is blank the cycle after entering IDLE.
- Writes are accepted in any state and take effect on the next displayed use of that index. wr_addr ≥ MSG_LEN is ignored.
- There is no mid-frame tearing requirement beyond the rules above.
- Reset asserted mid-operation returns to IDLE immediately and restores the default buffer.

Optional Feature:
SEG_BLINK_EN
- Defined: in HOLD, the display blanks (an=F, seg=FF) during alternate scroll periods. The blink phase flips on each fc wrap. The phase is 0 (visible) on entry to HOLD.
- Not defined: HOLD shows the frozen message steadily.
- RUN and IDLE are identical in both builds.

Test Plan:
- Reset mid-RUN, then release → an=F, seg=FF, busy=0 within the reset cycle. Defaults are read back by scanning in RUN.
- REFRESH_DIV=2, SCROLL_FRAMES=2: start pulse → first output cycle an=0111 seg=C7; 2 cycles later an=1011 seg=A3; then 1101/C7, 1110/EF. After 16 cycles the offset is 1 and the leftmost digit shows A3.
- Run 80 cycles after start → exactly one wrap pulse, at the step where offset returns to 0, leftmost again C7.
- In RUN assert stop → HOLD, busy=1, offset frozen for 64 cycles. Then start → resumes scrolling from the same offset. Then stop twice → IDLE, outputs FF/F.
- start and stop asserted together in IDLE → stays IDLE. The same in RUN → HOLD.
- Write wr_addr=2 wr_data=8'h88 during RUN → next lit occurrence of index 2 shows 88. wr_addr=9 with MSG_LEN=5 → no change.
- With SEG_BLINK_EN and REFRESH_DIV=2, SCROLL_FRAMES=2 in HOLD → 16 cycles visible, 16 blank, alternating.

Source files
------------

// File: rtl/seg_scroll_ctrl.sv
// Four-digit multiplexed seven-segment scroller with run/hold/idle control.
// Define SEG_BLINK_EN to blank the display on alternate scroll periods in HOLD.
module seg_scroll_ctrl #(
  parameter int REFRESH_DIV   = 4,
  parameter int SCROLL_FRAMES = 2,
  parameter int MSG_LEN       = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       stop,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       busy,
  output logic       wrap
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rc_q, rc_d;
  logic [1:0]      d_q, d_d;
  logic [FW-1:0]   fc_q, fc_d;
  logic [3:0]      off_q, off_d;
  logic [7:0]      msg_q [16];
  logic [7:0]      msg_d [16];
  logic [3:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic            wrap_q, wrap_d;
  logic            tick, frame_end, step;
  logic            blank;
  logic [4:0]      sum;
  logic [3:0]      idx;

  function automatic logic [7:0] def_code(input int i);
    case (i)
      0:       return 8'hC7;
      1:       return 8'hA3;
      2:       return 8'hC7;
      3:       return 8'hEF;
      4:       return 8'h89;
      default: return 8'hFF;
    endcase
  endfunction

  assign tick      = (state_q != IDLE) && (rc_q == RW'(REFRESH_DIV - 1));
  assign frame_end = tick && (d_q == 2'd3);
  assign step      = frame_end && (fc_q == FW'(SCROLL_FRAMES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !stop) state_d = RUN;
      RUN:     if (stop) state_d = HOLD;
      HOLD: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rc_d   = rc_q;
    d_d    = d_q;
    fc_d   = fc_q;
    off_d  = off_q;
    wrap_d = 1'b0;
    if (state_q == IDLE) begin
      rc_d  = '0;
      d_d   = '0;
      fc_d  = '0;
      off_d = '0;
    end else begin
      rc_d = tick ? '0 : rc_q + 1'b1;
      if (tick) d_d = d_q + 2'd1;
      if (frame_end) fc_d = step ? '0 : fc_q + 1'b1;
      // Offset only moves while running; HOLD freezes the message
      if (step && state_q == RUN) begin
        if (off_q == 4'(MSG_LEN - 1)) begin
          off_d  = '0;
          wrap_d = 1'b1;
        end else begin
          off_d = off_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    msg_d = msg_q;
    if (wr_en && ({1'b0, wr_addr} < 5'(MSG_LEN)))
      msg_d[wr_addr] = wr_data;
  end

`ifdef SEG_BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = 1'b0;
    if (state_q == HOLD) blink_d = step ? ~blink_q : blink_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) blink_q <= 1'b0;
    else       blink_q <= blink_d;
  end

  assign blank = (state_q == IDLE) || (state_q == HOLD && blink_q);
`else
  assign blank = (state_q == IDLE);
`endif

  assign sum = {1'b0, off_q} + {3'b000, d_q};
  assign idx = 4'(sum % 5'(MSG_LEN));

  always_comb begin
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (!blank) begin
      an_d  = ~(4'b1000 >> d_q);
      seg_d = msg_q[idx];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      rc_q    <= '0;
      d_q     <= '0;
      fc_q    <= '0;
      off_q   <= '0;
      an_q    <= 4'hF;
      seg_q   <= 8'hFF;
      wrap_q  <= 1'b0;
      for (int i = 0; i < 16; i++) msg_q[i] <= def_code(i);
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      d_q     <= d_d;
      fc_q    <= fc_d;
      off_q   <= off_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      wrap_q  <= wrap_d;
      msg_q   <= msg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign wrap = wrap_q;
  assign busy = (state_q != IDLE);

endmodule
